// File: rtl/alu_op_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_seq_if
//  Description : Bundles the three signal groups around alu_op_seq:
//                - operation intake handshake (in_*)
//                - ALU operand/function/enable pins and ALU results (alu_*)
//                - result drain handshake (out_*)
//                The 'slave' modport is the sequencer's view; the 'master'
//                modport is the surrounding environment (producer, ALU and
//                consumer taken together).
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_op_seq_if;
    // operation intake
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_f;
    logic       in_acc;
    // ALU pins (operands out, results in)
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_f;
    logic       alu_oe;
    logic [3:0] alu_y;
    logic       alu_p;
    logic       alu_ov;
    logic       alu_gt;
    logic       alu_eq;
    logic       alu_lt;
    // result drain
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_y;
    logic [4:0] out_flags;

    modport slave (
        input  in_valid, in_a, in_b, in_f, in_acc,
        output in_ready,
        output alu_a, alu_b, alu_f, alu_oe,
        input  alu_y, alu_p, alu_ov, alu_gt, alu_eq, alu_lt,
        output out_valid, out_y, out_flags,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_f, in_acc,
        input  in_ready,
        input  alu_a, alu_b, alu_f, alu_oe,
        output alu_y, alu_p, alu_ov, alu_gt, alu_eq, alu_lt,
        input  out_valid, out_y, out_flags,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_seq
//  Description : Operand sequencer and result buffer wrapped around a 4-bit
//                combinational ALU. Accepts one operation per handshake,
//                presents it to the ALU for a single EXEC cycle with alu_oe
//                high, captures {y, p, ov, gt, eq, lt} at the end of that
//                cycle into a circular result buffer, and serves the buffer
//                head over a valid/ready drain port.
//  Ports       : clk        rising-edge clock
//                rst_n      synchronous active-low reset
//                bus        alu_op_seq_if.slave (in_*, alu_*, out_* groups)
//  Parameters  : RES_DEPTH  result buffer entries (power of two, >= 2)
//  Build macro : ALU_SEQ_ACC_EN - adds a 4-bit accumulator loaded with alu_y
//                at every capture; an accepted op with in_acc=1 takes its
//                a operand from the accumulator. Undefined: in_acc ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_seq #(
    parameter int RES_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_seq_if.slave      bus
);

    // Pointers index RES_DEPTH entries; count needs one extra bit to hold
    // the full value. Power-of-two depth lets pointers wrap by overflow.
    localparam int              c_PW    = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int              c_CW    = $clog2(RES_DEPTH) + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(RES_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t          state_q,  state_d;
    logic [3:0]      alu_a_q,  alu_a_d;
    logic [3:0]      alu_b_q,  alu_b_d;
    logic [1:0]      alu_f_q,  alu_f_d;
    logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CW-1:0] count_q,  count_d;
    logic [3:0]      y_mem_q     [RES_DEPTH];
    logic [3:0]      y_mem_d     [RES_DEPTH];
    logic [4:0]      flags_mem_q [RES_DEPTH];
    logic [4:0]      flags_mem_d [RES_DEPTH];

    logic            w_in_ready;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_out_valid;
    logic [3:0]      w_op_a;

    // ------------------------------------------------------------------
    // Operand a source
    // ------------------------------------------------------------------
`ifdef ALU_SEQ_ACC_EN
    logic [3:0]      acc_q, acc_d;

    assign w_op_a = bus.in_acc ? acc_q : bus.in_a;

    always_comb begin
        acc_d = acc_q;
        if (w_push) begin
            acc_d = bus.alu_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic            w_unused;

    assign w_unused = bus.in_acc;
    assign w_op_a   = bus.in_a;
`endif

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    // Acceptance is gated on free space, so the capture one cycle later can
    // never find the buffer full (count only shrinks in between).
    assign w_in_ready  = (state_q == S_IDLE) && (count_q < c_DEPTH);
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_push      = (state_q == S_EXEC);
    assign w_out_valid = (count_q != '0);
    assign w_pop       = w_out_valid && bus.out_ready;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_f_d     = alu_f_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        y_mem_d     = y_mem_q;
        flags_mem_d = flags_mem_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    alu_a_d = w_op_a;
                    alu_b_d = bus.in_b;
                    alu_f_d = bus.in_f;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_push) begin
            y_mem_d[wr_ptr_q]     = bus.alu_y;
            flags_mem_d[wr_ptr_q] = {bus.alu_p, bus.alu_ov, bus.alu_gt,
                                     bus.alu_eq, bus.alu_lt};
            wr_ptr_d              = wr_ptr_q + c_PW'(1);
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PW'(1);
        end

        // Simultaneous push and pop leaves count unchanged.
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers; reset discards any in-flight operation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_f_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            y_mem_q     <= '{default: '0};
            flags_mem_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_f_q     <= alu_f_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            y_mem_q     <= y_mem_d;
            flags_mem_q <= flags_mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_f     = alu_f_q;
    assign bus.alu_oe    = (state_q == S_EXEC);
    assign bus.out_valid = w_out_valid;
    assign bus.out_y     = y_mem_q[rd_ptr_q];
    assign bus.out_flags = flags_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_alu_op_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_seq
//  Description : Directed self-checking bench for alu_op_seq. A behavioural
//                4-bit ALU (add/sub/and/xor, p = parity of y, ov = carry or
//                borrow, unsigned compares) closes the loop; expected results
//                are hand-computed constants. Honours ALU_SEQ_ACC_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_op_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

`ifdef ALU_SEQ_ACC_EN
    localparam logic [3:0] c_ACC_A     = 4'h6;
    localparam logic [3:0] c_ACC_Y     = 4'h9;
    localparam logic [4:0] c_ACC_FLAGS = 5'b00100;
`else
    localparam logic [3:0] c_ACC_A     = 4'h0;
    localparam logic [3:0] c_ACC_Y     = 4'h3;
    localparam logic [4:0] c_ACC_FLAGS = 5'b00001;
`endif

    alu_op_seq_if bus ();

    alu_op_seq #(.RES_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; outputs forced low when not enabled so a capture
    // outside EXEC would be visible.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum    = '0;
        bus.alu_y  = '0;
        bus.alu_p  = 1'b0;
        bus.alu_ov = 1'b0;
        bus.alu_gt = 1'b0;
        bus.alu_eq = 1'b0;
        bus.alu_lt = 1'b0;
        case (bus.alu_f)
            2'b00:   alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            2'b01:   alu_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            2'b10:   alu_sum = {1'b0, bus.alu_a & bus.alu_b};
            default: alu_sum = {1'b0, bus.alu_a ^ bus.alu_b};
        endcase
        if (bus.alu_oe) begin
            bus.alu_y  = alu_sum[3:0];
            bus.alu_p  = ^alu_sum[3:0];
            bus.alu_ov = alu_sum[4];
            bus.alu_gt = (bus.alu_a > bus.alu_b);
            bus.alu_eq = (bus.alu_a == bus.alu_b);
            bus.alu_lt = (bus.alu_a < bus.alu_b);
        end
    end

    // Offer one op starting at a falling edge; returns at the falling edge
    // after the accepting rising edge (i.e. inside EXEC), or ok=0 on timeout.
    task automatic send_op(input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] f, input logic acc, output bit ok);
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_f     = f;
        bus.in_acc   = acc;
        for (int n = 0; n < 16 && !ok; n++) begin
            if (bus.in_ready) ok = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_acc   = 1'b0;
    endtask

    task automatic pop_one;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_f      = '0;
        bus.in_acc    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.alu_oe !== 1'b0) begin
            errors++; $display("FAIL reset_oe: got %b expected 0", bus.alu_oe);
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_f} !== 10'h000) begin
            errors++; $display("FAIL reset_abf: got %h/%h/%h expected 0/0/0", bus.alu_a, bus.alu_b, bus.alu_f);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_add;
        bit ok;
        send_op(4'd7, 4'd9, 2'b00, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL add_accept: got no accept expected accept");
        end
        checks++;
        if ({bus.alu_oe, bus.in_ready, bus.out_valid} !== 3'b100) begin
            errors++; $display("FAIL add_exec_ctl: got oe/rdy/ov=%b expected 100", {bus.alu_oe, bus.in_ready, bus.out_valid});
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_f} !== {4'd7, 4'd9, 2'b00}) begin
            errors++; $display("FAIL add_operands: got %h/%h/%h expected 7/9/0", bus.alu_a, bus.alu_b, bus.alu_f);
        end
        @(negedge clk);
        checks++;
        if ({bus.alu_oe, bus.out_valid} !== 2'b01) begin
            errors++; $display("FAIL add_after: got oe/valid=%b expected 01", {bus.alu_oe, bus.out_valid});
        end
        checks++;
        if ({bus.out_y, bus.out_flags} !== {4'b0000, 5'b01001}) begin
            errors++; $display("FAIL add_result: got y=%b flags=%b expected y=0000 flags=01001", bus.out_y, bus.out_flags);
        end
        pop_one();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL add_pop: got valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_sub;
        bit ok;
        send_op(4'd3, 4'd5, 2'b01, 1'b0, ok);
        @(negedge clk);
        checks++;
        if (!ok || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL sub_valid: got ok=%b valid=%b expected 1/1", ok, bus.out_valid);
        end
        checks++;
        if ({bus.out_y, bus.out_flags} !== {4'b1110, 5'b11001}) begin
            errors++; $display("FAIL sub_result: got y=%b flags=%b expected y=1110 flags=11001", bus.out_y, bus.out_flags);
        end
        pop_one();
    endtask

    task automatic test_backpressure;
        bit ok1, ok2;
        int seen;
        bus.out_ready = 1'b0;
        send_op(4'd1, 4'd2, 2'b00, 1'b0, ok1);
        send_op(4'd5, 4'd5, 2'b11, 1'b0, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++; $display("FAIL bp_accept2: got ok=%b%b expected 11", ok1, ok2);
        end
        // third op offered while the buffer fills up
        bus.in_valid = 1'b1;
        bus.in_a     = 4'd12;
        bus.in_b     = 4'd10;
        bus.in_f     = 2'b10;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.in_ready) seen++;
        end
        checks++;
        if (seen != 0 || bus.alu_oe !== 1'b0) begin
            errors++; $display("FAIL bp_stall: got ready cycles=%0d oe=%b expected 0/0", seen, bus.alu_oe);
        end
        checks++;
        if ({bus.out_valid, bus.out_y, bus.out_flags} !== {1'b1, 4'b0011, 5'b00001}) begin
            errors++; $display("FAIL bp_head1: got v=%b y=%b f=%b expected 1/0011/00001", bus.out_valid, bus.out_y, bus.out_flags);
        end
        pop_one();
        checks++;
        if ({bus.in_ready, bus.out_y, bus.out_flags} !== {1'b1, 4'b0000, 5'b00010}) begin
            errors++; $display("FAIL bp_head2: got rdy=%b y=%b f=%b expected 1/0000/00010", bus.in_ready, bus.out_y, bus.out_flags);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.alu_oe, bus.alu_a, bus.alu_b} !== {1'b1, 4'd12, 4'd10}) begin
            errors++; $display("FAIL bp_third_exec: got oe=%b a=%h b=%h expected 1/c/a", bus.alu_oe, bus.alu_a, bus.alu_b);
        end
        @(negedge clk);
        pop_one();
        checks++;
        if ({bus.out_valid, bus.out_y, bus.out_flags} !== {1'b1, 4'b1000, 5'b10100}) begin
            errors++; $display("FAIL bp_head3: got v=%b y=%b f=%b expected 1/1000/10100", bus.out_valid, bus.out_y, bus.out_flags);
        end
        pop_one();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drained: got valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] oa [4] = '{4'd2, 4'd8, 4'd9, 4'd15};
        logic [3:0] ob [4] = '{4'd3, 4'd8, 4'd4, 4'd1};
        logic [1:0] of [4] = '{2'b00, 2'b01, 2'b11, 2'b00};
        logic [3:0] ey [4] = '{4'b0101, 4'b0000, 4'b1101, 4'b0000};
        logic [4:0] ef [4] = '{5'b00001, 5'b00010, 5'b10100, 5'b01100};
        bit all_ok;
        int idx;
        int run;
        int max_run;
        all_ok  = 1'b1;
        idx     = 0;
        run     = 0;
        max_run = 0;
        bus.out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    bit ok;
                    send_op(oa[k], ob[k], of[k], 1'b0, ok);
                    all_ok = all_ok && ok;
                end
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (bus.out_valid) begin
                        run++;
                        if (run > max_run) max_run = run;
                        if (idx < 4) begin
                            checks++;
                            if ({bus.out_y, bus.out_flags} !== {ey[idx], ef[idx]}) begin
                                errors++; $display("FAIL b2b_result%0d: got y=%b f=%b expected y=%b f=%b", idx, bus.out_y, bus.out_flags, ey[idx], ef[idx]);
                            end
                        end
                        idx++;
                    end else begin
                        run = 0;
                    end
                end
            end
        join
        bus.out_ready = 1'b0;
        checks++;
        if (!all_ok || idx != 4) begin
            errors++; $display("FAIL b2b_count: got accepted_all=%b results=%0d expected 1/4", all_ok, idx);
        end
        checks++;
        if (max_run > 1) begin
            errors++; $display("FAIL b2b_occupancy: got head held %0d cycles expected 1", max_run);
        end
    endtask

    task automatic test_reset_mid_exec;
        bit ok;
        bus.out_ready = 1'b0;
        send_op(4'd4, 4'd4, 2'b00, 1'b0, ok);
        checks++;
        if (!ok || bus.alu_oe !== 1'b1) begin
            errors++; $display("FAIL rst_exec_setup: got ok=%b oe=%b expected 1/1", ok, bus.alu_oe);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.alu_oe, bus.alu_a, bus.out_valid, bus.in_ready} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rst_exec_state: got oe=%b a=%h v=%b rdy=%b expected 0/0/0/1", bus.alu_oe, bus.alu_a, bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_exec_discard: got valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_accumulator;
        bit ok;
        bus.out_ready = 1'b0;
        send_op(4'hF, 4'h6, 2'b10, 1'b0, ok);
        @(negedge clk);
        checks++;
        if ({bus.out_y, bus.out_flags} !== {4'h6, 5'b00100}) begin
            errors++; $display("FAIL acc_first: got y=%b f=%b expected 0110/00100", bus.out_y, bus.out_flags);
        end
        pop_one();
        send_op(4'h0, 4'h3, 2'b00, 1'b1, ok);
        checks++;
        if (bus.alu_a !== c_ACC_A) begin
            errors++; $display("FAIL acc_operand: got alu_a=%h expected %h", bus.alu_a, c_ACC_A);
        end
        @(negedge clk);
        checks++;
        if ({bus.out_y, bus.out_flags} !== {c_ACC_Y, c_ACC_FLAGS}) begin
            errors++; $display("FAIL acc_result: got y=%b f=%b expected %b/%b", bus.out_y, bus.out_flags, c_ACC_Y, c_ACC_FLAGS);
        end
        pop_one();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_exec();
        test_accumulator();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
